roce_responder_ack_gen: RTL

Responder-side RC reliability engine: the counterpart of the requester QP state tracker that consumes ACK/NAK. Sits after the RX BTH parser. It checks the incoming RDMA WRITE/SEND PSN sequence for one QP and maintains the expected PSN (ePSN) and MSN. It emits ACK/NAK descriptors (BTH and AETH fields) to the TX header generator.

---
 rtl/roce_pkg.sv | 22 ++
 rtl/roce_responder_ack_gen_if.sv | 27 ++
 rtl/roce_psn_classifier.sv | 16 +
 rtl/roce_responder_ack_gen.sv | 97 +++++++++
 4 files changed

// File: rtl/roce_pkg.sv
// roce_pkg: shared RoCE RC opcodes, AETH syndromes, responder states and PSN arithmetic
package roce_pkg;
  localparam logic [7:0] RC_SEND_FIRST          = 8'h00;
  localparam logic [7:0] RC_SEND_MIDDLE         = 8'h01;
  localparam logic [7:0] RC_SEND_LAST           = 8'h02;
  localparam logic [7:0] RC_SEND_LAST_IMD       = 8'h03;
  localparam logic [7:0] RC_SEND_ONLY           = 8'h04;
  localparam logic [7:0] RC_SEND_ONLY_IMD       = 8'h05;
  localparam logic [7:0] RC_RDMA_WRITE_FIRST    = 8'h06;
  localparam logic [7:0] RC_RDMA_WRITE_MIDDLE   = 8'h07;
  localparam logic [7:0] RC_RDMA_WRITE_LAST     = 8'h08;
  localparam logic [7:0] RC_RDMA_WRITE_LAST_IMD = 8'h09;
  localparam logic [7:0] RC_RDMA_WRITE_ONLY     = 8'h0A;
  localparam logic [7:0] RC_RDMA_WRITE_ONLY_IMD = 8'h0B;
  localparam logic [7:0] RC_RDMA_ACK            = 8'h11;
  localparam logic [7:0] AETH_ACK_NOCREDIT      = 8'h1F;
  localparam logic [7:0] AETH_NAK_PSN_SEQ       = 8'h60;
  typedef enum logic [1:0] {ST_DISABLED, ST_ACTIVE, ST_NAK_SENT} resp_state_t;
  function automatic logic [23:0] psn_diff(input logic [23:0] a, input logic [23:0] b);
    return a - b;
  endfunction
endpackage

// File: rtl/roce_responder_ack_gen_if.sv
// roce_responder_ack_gen_if: RX BTH stream into the responder and ACK/NAK descriptor stream out of it
interface roce_responder_ack_gen_if;
  logic        s_roce_rx_bth_valid;
  logic        s_roce_rx_bth_ready;
  logic [7:0]  s_roce_rx_bth_op_code;
  logic [23:0] s_roce_rx_bth_psn;
  logic [23:0] s_roce_rx_bth_dest_qp;
  logic        s_roce_rx_bth_ack_req;
  logic        m_roce_ack_valid;
  logic        m_roce_ack_ready;
  logic [23:0] m_roce_ack_dest_qp;
  logic [23:0] m_roce_ack_psn;
  logic [7:0]  m_roce_ack_syndrome;
  logic [23:0] m_roce_ack_msn;
  modport slave (
    input  s_roce_rx_bth_valid, s_roce_rx_bth_op_code, s_roce_rx_bth_psn, s_roce_rx_bth_dest_qp,
           s_roce_rx_bth_ack_req, m_roce_ack_ready,
    output s_roce_rx_bth_ready, m_roce_ack_valid, m_roce_ack_dest_qp, m_roce_ack_psn,
           m_roce_ack_syndrome, m_roce_ack_msn
  );
  modport master (
    output s_roce_rx_bth_valid, s_roce_rx_bth_op_code, s_roce_rx_bth_psn, s_roce_rx_bth_dest_qp,
           s_roce_rx_bth_ack_req, m_roce_ack_ready,
    input  s_roce_rx_bth_ready, m_roce_ack_valid, m_roce_ack_dest_qp, m_roce_ack_psn,
           m_roce_ack_syndrome, m_roce_ack_msn
  );
endinterface

// File: rtl/roce_psn_classifier.sv
// roce_psn_classifier: sorts a PSN against the expected PSN into in-order / duplicate / out-of-sequence
module roce_psn_classifier
  import roce_pkg::*;
(
  input  logic [23:0] psn,
  input  logic [23:0] epsn,
  output logic        in_order,
  output logic        dup,
  output logic        oos
);
  logic [23:0] d;
  assign d        = psn_diff(psn, epsn);
  assign in_order = d == 24'd0;
  assign dup      = d[23];
  assign oos      = !in_order && !d[23];
endmodule

// File: rtl/roce_responder_ack_gen.sv
// roce_responder_ack_gen: responder-side RC PSN checker and ACK/NAK descriptor generator for one QP.
// Define ROCE_ACK_COALESCE_EN to force an ACK after every ACK_COALESCE in-order packets without ack_req.
module roce_responder_ack_gen
  import roce_pkg::*;
#(
  parameter int ACK_COALESCE = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 qp_load,
  input  logic [23:0]          qp_loc_qpn,
  input  logic [23:0]          qp_rem_qpn,
  input  logic [23:0]          qp_init_epsn,
  roce_responder_ack_gen_if.slave bus,
  output logic [23:0]          epsn,
  output logic [CNT_WIDTH-1:0] dup_cnt,
  output logic [CNT_WIDTH-1:0] oos_cnt
);
  if (ACK_COALESCE < 1) begin : g_chk
    $error("ACK_COALESCE must be at least 1");
  end
  resp_state_t state;
  logic [23:0] loc_qpn, rem_qpn, msn, msn_nx, q_psn;
  logic ack_nak, acc, good, in_order, dup, oos, is_last, coal_hit, q_ack, q_nak, queue, take;
  roce_psn_classifier u_cls (
    .psn      (bus.s_roce_rx_bth_psn),
    .epsn     (epsn),
    .in_order (in_order),
    .dup      (dup),
    .oos      (oos)
  );
  // A pending NAK must reach the requester, so it back-pressures the BTH stream instead of being overwritten
  assign bus.s_roce_rx_bth_ready = state != ST_DISABLED && !qp_load && !(bus.m_roce_ack_valid && ack_nak);
  assign bus.m_roce_ack_dest_qp  = rem_qpn;
  assign acc     = bus.s_roce_rx_bth_valid && bus.s_roce_rx_bth_ready;
  assign good    = acc && bus.s_roce_rx_bth_dest_qp == loc_qpn && bus.s_roce_rx_bth_op_code <= RC_RDMA_WRITE_ONLY_IMD;
  assign is_last = !(bus.s_roce_rx_bth_op_code inside {RC_SEND_FIRST, RC_SEND_MIDDLE, RC_RDMA_WRITE_FIRST, RC_RDMA_WRITE_MIDDLE});
  assign msn_nx  = msn + 24'(good && in_order && is_last);
  assign q_ack   = good && ((in_order && (bus.s_roce_rx_bth_ack_req || coal_hit)) || (dup && bus.s_roce_rx_bth_ack_req));
  assign q_nak   = good && oos && state == ST_ACTIVE;
  assign queue   = q_ack || q_nak;
  assign q_psn   = q_nak ? epsn : dup ? epsn - 24'd1 : bus.s_roce_rx_bth_psn;
  assign take    = bus.m_roce_ack_valid && bus.m_roce_ack_ready;
`ifdef ROCE_ACK_COALESCE_EN
  localparam int CW = $clog2(ACK_COALESCE + 1);
  logic [CW-1:0] coal_cnt;
  assign coal_hit = good && in_order && !bus.s_roce_rx_bth_ack_req && coal_cnt == CW'(ACK_COALESCE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) coal_cnt <= '0;
    else if (qp_load || queue) coal_cnt <= '0;
    else if (good && in_order) coal_cnt <= coal_cnt + 1'b1;
`else
  assign coal_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_DISABLED;
      loc_qpn                 <= '0;
      rem_qpn                 <= '0;
      epsn                    <= '0;
      msn                     <= '0;
      dup_cnt                 <= '0;
      oos_cnt                 <= '0;
      ack_nak                 <= 1'b0;
      bus.m_roce_ack_valid    <= 1'b0;
      bus.m_roce_ack_psn      <= '0;
      bus.m_roce_ack_syndrome <= '0;
      bus.m_roce_ack_msn      <= '0;
    end else if (qp_load) begin
      state                <= ST_ACTIVE;
      loc_qpn              <= qp_loc_qpn;
      rem_qpn              <= qp_rem_qpn;
      epsn                 <= qp_init_epsn;
      msn                  <= '0;
      dup_cnt              <= '0;
      oos_cnt              <= '0;
      ack_nak              <= 1'b0;
      bus.m_roce_ack_valid <= 1'b0;
    end else begin
      msn <= msn_nx;
      if (good && in_order) begin
        epsn  <= epsn + 24'd1;
        state <= ST_ACTIVE;
      end else if (q_nak) state <= ST_NAK_SENT;
      if (good && dup && !(&dup_cnt)) dup_cnt <= dup_cnt + 1'b1;
      if (good && oos && !(&oos_cnt)) oos_cnt <= oos_cnt + 1'b1;
      if (queue) begin
        bus.m_roce_ack_valid    <= 1'b1;
        ack_nak                 <= q_nak;
        bus.m_roce_ack_psn      <= q_psn;
        bus.m_roce_ack_syndrome <= q_nak ? AETH_NAK_PSN_SEQ : AETH_ACK_NOCREDIT;
        bus.m_roce_ack_msn      <= msn_nx;
      end else if (take) bus.m_roce_ack_valid <= 1'b0;
    end
  end
endmodule
